wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL take parameter STARVE_LIMIT, default 4, range 1..7: the number of cycles a buffered MDU result waits behind pipeline writes before a stall is requested.
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on its rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  wb_regwrite  in  1  WB-stage register-write request.
  wb_memtoreg  in  1  1 selects wb_memdata, 0 selects wb_aluresult.
  wb_memdata  in  16  load data from WB stage.
  wb_aluresult  in  16  ALU result from WB stage.
  wb_regdst  in  4  WB destination register.
  mdu_valid  in  1  multi-cycle unit result offered.
  mdu_ready  out  1  buffer accepts an MDU result this cycle.
  mdu_data  in  16  MDU result.
  mdu_dst  in  4  MDU destination register.
  rf_we  out  1  register-file write enable.
  rf_waddr  out  4  register-file write address.
  rf_wdata  out  16  register-file write data.
  rf_src  out  1  source of current write: 0 pipeline, 1 MDU.
  pipe_stall  out  1  request to the core to insert a WB bubble.

Function
REQ-003 The block SHALL own the single register-file write port and share it between the WB stage (requester P) and a 2-entry FIFO of MDU results (requester M).
REQ-004 The block SHALL push an MDU result when mdu_valid and mdu_ready are both 1 at a rising edge; mdu_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries, taken from registered occupancy.
REQ-005 When the FIFO is full, mdu_ready SHALL be 0 even in a cycle where the head is popped; mdu_valid SHALL be ignored.
REQ-006 P requests in a cycle when wb_regwrite=1 and wb_regdst!=0; a write to register 0 SHALL be discarded with no port use.
REQ-007 M requests when the FIFO is non-empty; a head entry with mdu_dst=0 SHALL be popped with no write and SHALL take no grant.
REQ-008 Priority: P SHALL win over M, except while pipe_stall=1 as in REQ-011.
REQ-009 A granted write SHALL appear on rf_we/rf_waddr/rf_wdata/rf_src registered, one cycle after the request cycle. P data SHALL be wb_memdata if wb_memtoreg=1, else wb_aluresult.
REQ-010 A 3-bit age counter SHALL clear when the FIFO is empty or the head is popped. It SHALL increment, saturating at STARVE_LIMIT, on each cycle the head loses to P.
REQ-011 pipe_stall SHALL be registered and go to 1 the cycle after age reaches STARVE_LIMIT. It SHALL stay 1 until a cycle with no P request. In that cycle M is granted, and pipe_stall SHALL return to 0 at the next edge.
REQ-012 A push and a pop in the same cycle SHALL leave occupancy unchanged. A push into an empty FIFO SHALL NOT be granted in the same cycle; the write is earliest in the next cycle.
REQ-013 The FIFO SHALL preserve MDU order; a pop SHALL happen only on an M grant or a discard under REQ-007.
REQ-014 The block SHALL never write two values in one cycle and SHALL never drop a P write whose regdst is not 0.

Reset
REQ-015 While rst_n=0 the block SHALL asynchronously force rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0, pipe_stall=0, FIFO empty, age=0.
REQ-016 mdu_ready SHALL be 1 during and after reset; FIFO contents SHALL be discarded.
REQ-017 Release of rst_n SHALL take effect at the first rising edge of clk with rst_n=1.
REQ-018 Reset asserted mid-stall or with the FIFO full SHALL leave no write pending after release.

Verification
REQ-019 P-only test: wb_regwrite=1, regdst=5, memtoreg=0, aluresult=16'h1234 -> next cycle rf_we=1, waddr=5, wdata=16'h1234, src=0.
REQ-020 Zero-register test: wb_regwrite=1, regdst=0 -> rf_we=0; an MDU head present in the same cycle is granted instead.
REQ-021 Backpressure test: push 16'hAAAA to r3 and 16'hBBBB to r4 while P writes every cycle -> mdu_ready=0 after the second push. The third offer is held until a pop. The entries are later written in order r3 then r4.
REQ-022 Starvation test with STARVE_LIMIT=4: P writes continuously with the FIFO non-empty -> pipe_stall rises on the 5th cycle of waiting. It stays high until wb_regwrite=0. In that cycle the MDU head is granted (src=1), and pipe_stall falls next.
REQ-023 Simultaneous test: FIFO holds 1 entry, wb_regwrite=0, mdu_valid=1 -> head written, new entry pushed, occupancy stays 1, mdu_ready stays 1.
REQ-024 Reset test: assert rst_n=0 with FIFO full and pipe_stall=1 -> all outputs 0 immediately, mdu_ready=1. No rf_we pulse after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the single write port between the WB
// stage and a 2-entry FIFO of multi-cycle-unit results, with starvation stall.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic        wb_memtoreg,
    input  logic [15:0] wb_memdata,
    input  logic [15:0] wb_aluresult,
    input  logic [3:0]  wb_regdst,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [15:0] mdu_data,
    input  logic [3:0]  mdu_dst,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        rf_src,
    output logic        pipe_stall
);

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned AGEW  = 3;
    localparam int unsigned DEPTH = 2;
    localparam logic [AGEW-1:0] AGE_MAX = AGEW'(STARVE_LIMIT);

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } mdu_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } stall_state_t;

    mdu_entry_t      fifo_q [DEPTH];
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic [AGEW-1:0] age_q;
    stall_state_t    state_q;

    mdu_entry_t      head;
    logic            p_req;
    logic            m_req;
    logic            head_zero;
    logic            m_grant;
    logic            pop;
    logic            push;
    logic            wr_ptr;
    logic [1:0]      count_d;
    logic [AGEW-1:0] age_d;
    stall_state_t    state_d;
    logic [DW-1:0]   p_data;

    // Ready depends only on registered occupancy, so a full FIFO refuses even while popping.
    assign mdu_ready  = (count_q != 2'(DEPTH));
    assign pipe_stall = (state_q == ST_STALL);

    // Request decode, grant, FIFO bookkeeping, age and stall next-state.
    always_comb begin
        head      = fifo_q[rd_ptr_q];
        p_req     = wb_regwrite && (wb_regdst != '0);
        m_req     = (count_q != '0);
        head_zero = m_req && (head.dst == '0);
        m_grant   = m_req && !head_zero && !p_req;
        pop       = m_grant || head_zero;
        push      = mdu_valid && mdu_ready;
        wr_ptr    = rd_ptr_q ^ count_q[0];
        p_data    = wb_memtoreg ? wb_memdata : wb_aluresult;
        count_d   = count_q + 2'(push) - 2'(pop);

        age_d = age_q;
        if (!m_req || pop) begin
            age_d = '0;
        end else if (age_q < AGE_MAX) begin
            age_d = age_q + AGEW'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (age_d == AGE_MAX) state_d = ST_STALL;
            ST_STALL: if (!p_req)           state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State register and FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            age_q     <= '0;
            count_q   <= '0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            count_q <= count_d;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            if (push) fifo_q[wr_ptr] <= '{dst: mdu_dst, data: mdu_data};
        end
    end

    // Registered write port; WB stage always wins when it has a real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_src   <= 1'b0;
        end else if (p_req) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_regdst;
            rf_wdata <= p_data;
            rf_src   <= 1'b0;
        end else if (m_grant) begin
            rf_we    <= 1'b1;
            rf_waddr <= head.dst;
            rf_wdata <= head.data;
            rf_src   <= 1'b1;
        end else begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_src   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Vector-table bench for wb_port_arbiter: each vector's expected write-port result
// is queued when it is driven and compared one edge later.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [15:0] wb_memdata;
    logic [15:0] wb_aluresult;
    logic [3:0]  wb_regdst;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [15:0] mdu_data;
    logic [3:0]  mdu_dst;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_src;
    logic        pipe_stall;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .wb_memdata   (wb_memdata),
        .wb_aluresult (wb_aluresult),
        .wb_regdst    (wb_regdst),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_data     (mdu_data),
        .mdu_dst      (mdu_dst),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_src       (rf_src),
        .pipe_stall   (pipe_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rw;
        logic        m2r;
        logic [15:0] memd;
        logic [15:0] alu;
        logic [3:0]  dst;
        logic        mv;
        logic [15:0] md;
        logic [3:0]  mdst;
        logic        ready;
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic        src;
        logic        stall;
    } vec_t;

    vec_t         tbl[$];
    logic [22:0]  exp_q[$];
    int           n_vec;
    int           n_miss;

    function automatic vec_t mk(string name, logic rw, logic m2r, logic [15:0] memd,
                                logic [15:0] alu, logic [3:0] dst, logic mv,
                                logic [15:0] md, logic [3:0] mdst, logic ready,
                                logic we, logic [3:0] waddr, logic [15:0] wdata,
                                logic src, logic stall);
        vec_t v;
        v.name = name; v.rw = rw; v.m2r = m2r; v.memd = memd; v.alu = alu; v.dst = dst;
        v.mv = mv; v.md = md; v.mdst = mdst; v.ready = ready; v.we = we; v.waddr = waddr;
        v.wdata = wdata; v.src = src; v.stall = stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [22:0] e;
        @(negedge clk);
        wb_regwrite  = v.rw;
        wb_memtoreg  = v.m2r;
        wb_memdata   = v.memd;
        wb_aluresult = v.alu;
        wb_regdst    = v.dst;
        mdu_valid    = v.mv;
        mdu_data     = v.md;
        mdu_dst      = v.mdst;
        #1;
        check({v.name, ".ready"}, 24'(mdu_ready), 24'(v.ready));
        exp_q.push_back({v.we, v.waddr, v.wdata, v.src, v.stall});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({v.name, ".port"}, 24'({rf_we, rf_waddr, rf_wdata, rf_src, pipe_stall}), 24'(e));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {rf_we, rf_waddr, rf_wdata, rf_src, pipe_stall, mdu_ready}, 24'h1);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n        = 1'b0;
        wb_regwrite  = 1'b0;
        wb_memtoreg  = 1'b0;
        wb_memdata   = '0;
        wb_aluresult = '0;
        wb_regdst    = '0;
        mdu_valid    = 1'b0;
        mdu_data     = '0;
        mdu_dst      = '0;

        //           name       rw m2r memd     alu      dst mv md       mdst rdy we wa  wdata    src stl
        tbl.push_back(mk("idle",   0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk("p_alu",  1, 0, 16'hFFFF, 16'h1234, 5, 0, 16'h0000, 0, 1, 1, 5, 16'h1234, 0, 0));
        tbl.push_back(mk("p_mem",  1, 1, 16'hBEEF, 16'h1111, 7, 0, 16'h0000, 0, 1, 1, 7, 16'hBEEF, 0, 0));
        tbl.push_back(mk("push1",  0, 0, 16'h0000, 16'h0000, 0, 1, 16'h5555, 9, 1, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk("zreg",   1, 0, 16'h0000, 16'hDEAD, 0, 0, 16'h0000, 0, 1, 1, 9, 16'h5555, 1, 0));
        tbl.push_back(mk("bp_a",   1, 0, 16'h0000, 16'h0101, 1, 1, 16'hAAAA, 3, 1, 1, 1, 16'h0101, 0, 0));
        tbl.push_back(mk("bp_b",   1, 0, 16'h0000, 16'h0202, 2, 1, 16'hBBBB, 4, 1, 1, 2, 16'h0202, 0, 0));
        tbl.push_back(mk("bp_w3",  1, 0, 16'h0000, 16'h0303, 1, 1, 16'hCCCC, 5, 0, 1, 1, 16'h0303, 0, 0));
        tbl.push_back(mk("bp_w4",  1, 0, 16'h0000, 16'h0404, 2, 1, 16'hCCCC, 5, 0, 1, 2, 16'h0404, 0, 0));
        tbl.push_back(mk("stv_up", 1, 0, 16'h0000, 16'h0505, 1, 1, 16'hCCCC, 5, 0, 1, 1, 16'h0505, 0, 1));
        tbl.push_back(mk("stv_hd", 1, 0, 16'h0000, 16'h0606, 2, 1, 16'hCCCC, 5, 0, 1, 2, 16'h0606, 0, 1));
        tbl.push_back(mk("stv_rl", 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hCCCC, 5, 0, 1, 3, 16'hAAAA, 1, 0));
        tbl.push_back(mk("simul",  0, 0, 16'h0000, 16'h0000, 0, 1, 16'hCCCC, 5, 1, 1, 4, 16'hBBBB, 1, 0));
        tbl.push_back(mk("drain",  0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 5, 16'hCCCC, 1, 0));
        tbl.push_back(mk("zpush",  0, 0, 16'h0000, 16'h0000, 0, 1, 16'h7777, 0, 1, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk("zdisc",  1, 0, 16'h0000, 16'h0808, 6, 1, 16'h9999, 8, 1, 1, 6, 16'h0808, 0, 0));
        tbl.push_back(mk("after",  0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 8, 16'h9999, 1, 0));
        tbl.push_back(mk("empty",  0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0));

        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Fill the FIFO and drive the arbiter into stall, then reset asynchronously.
        for (int i = 0; i < 6; i++) begin
            apply(mk("fill", 1, 0, 16'h0000, 16'(16'h1000 + i), 4'(1 + i), 1,
                     16'(16'h2000 + i), 4'(10 + i), (i < 2), 1, 4'(1 + i),
                     16'(16'h1000 + i), 0, (i >= 4)));
        end
        @(negedge clk);
        rst_n       = 1'b0;
        wb_regwrite = 1'b0;
        mdu_valid   = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(mk("post_rst", 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0,
                     16'h0000, 0, 0));
        end
        apply(mk("post_push", 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h4242, 2, 1, 0, 0,
                 16'h0000, 0, 0));
        apply(mk("post_wr", 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 2,
                 16'h4242, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
